// File: rtl/ex_stage.sv
// Execute stage: ID->EX register, one-hot ALU, data SRAM request,
// forwarding to ID and a 32-iteration restoring divider.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int EX_TO_ID_WD  = 39,
  parameter int StallBus     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  output logic                    stallreq,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic [64:0]             ex_hilo_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  logic [ID_TO_EX_WD-1:0] r_q, r_d;
  div_state_e             state_q, state_d;
  logic [31:0]            rem_q, rem_d;
  logic [31:0]            quot_q, quot_d;
  logic [31:0]            dvs_q, dvs_d;
  logic [5:0]             cnt_q, cnt_d;
  logic                   negq_q, negq_d;
  logic                   negr_q, negr_d;

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        ram_en, rf_we, sel_rf_res;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;

  assign pc         = r_q[158:127];
  assign inst       = r_q[126:95];
  assign alu_op     = r_q[94:83];
  assign sel_src1   = r_q[82:80];
  assign sel_src2   = r_q[79:76];
  assign ram_en     = r_q[75];
  assign ram_wen    = r_q[74:71];
  assign rf_we      = r_q[70];
  assign rf_waddr   = r_q[69:65];
  assign sel_rf_res = r_q[64];
  assign rdata1     = r_q[63:32];
  assign rdata2     = r_q[31:0];

  logic unused_ok;
  assign unused_ok = ^{stall[StallBus-1:4], stall[1:0], inst[25:16]};

  // Input register: bubble when ID stalls but EX moves, hold when both stall
  always_comb begin
    r_d = r_q;
    if (stall[2] && !stall[3]) begin
      r_d = '0;
    end else if (!stall[2]) begin
      r_d = id_to_ex_bus;
    end
  end

  logic [31:0] src1, src2, ex_result;

  // Operand selection from one-hot selects
  always_comb begin
    src1 = '0;
    src2 = '0;
    unique case (1'b1)
      sel_src1[0]: src1 = rdata1;
      sel_src1[1]: src1 = pc;
      sel_src1[2]: src1 = {27'b0, inst[10:6]};
      default:     src1 = '0;
    endcase
    unique case (1'b1)
      sel_src2[0]: src2 = rdata2;
      sel_src2[1]: src2 = {{16{inst[15]}}, inst[15:0]};
      sel_src2[2]: src2 = 32'd8;
      sel_src2[3]: src2 = {16'b0, inst[15:0]};
      default:     src2 = '0;
    endcase
  end

  // One-hot ALU, MSB is add down to lui at bit 0
  always_comb begin
    ex_result = '0;
    unique case (1'b1)
      alu_op[11]: ex_result = src1 + src2;
      alu_op[10]: ex_result = src1 - src2;
      alu_op[9]:  ex_result = {31'b0, $signed(src1) < $signed(src2)};
      alu_op[8]:  ex_result = {31'b0, src1 < src2};
      alu_op[7]:  ex_result = src1 & src2;
      alu_op[6]:  ex_result = ~(src1 | src2);
      alu_op[5]:  ex_result = src1 | src2;
      alu_op[4]:  ex_result = src1 ^ src2;
      alu_op[3]:  ex_result = src2 << src1[4:0];
      alu_op[2]:  ex_result = src2 >> src1[4:0];
      alu_op[1]:  ex_result = $signed(src2) >>> src1[4:0];
      alu_op[0]:  ex_result = {src2[15:0], 16'b0};
      default:    ex_result = '0;
    endcase
  end

  assign data_sram_en    = ram_en;
  assign data_sram_wen   = ram_wen;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = rdata2;

  assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res,
                          rf_we, rf_waddr, ex_result};
  assign ex_to_id_bus  = {sel_rf_res, rf_we, rf_waddr, ex_result};

  logic is_div, is_divs;
  assign is_divs = (inst[31:26] == 6'b0) && (inst[5:0] == 6'b011010);
  assign is_div  = (inst[31:26] == 6'b0) &&
                   ((inst[5:0] == 6'b011010) || (inst[5:0] == 6'b011011));

  logic        sa, sb;
  logic [32:0] trial, diff;
  logic [31:0] lo_res, hi_res;

  assign sa    = is_divs & rdata1[31];
  assign sb    = is_divs & rdata2[31];
  assign trial = {rem_q, quot_q[31]};
  assign diff  = trial - {1'b0, dvs_q};

  // Divider FSM: next state, iteration datapath and outputs
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    stallreq = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_div) begin
          stallreq = 1'b1;
          quot_d   = sa ? -rdata1 : rdata1;
          dvs_d    = sb ? -rdata2 : rdata2;
          rem_d    = '0;
          cnt_d    = '0;
          negq_d   = sa ^ sb;
          negr_d   = sa;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        stallreq = 1'b1;
        if (trial >= {1'b0, dvs_q}) begin
          rem_d  = diff[31:0];
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = trial[31:0];
          quot_d = {quot_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = DONE;
      end
      DONE: begin
        if (!stall[2]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign lo_res = negq_q ? -quot_q : quot_q;
  assign hi_res = negr_q ? -rem_q : rem_q;
  assign ex_hilo_bus = (state_q == DONE) ? {1'b1, hi_res, lo_res} : '0;

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= '0;
      state_q <= IDLE;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      r_q     <= r_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, stalls, store request,
// signed/unsigned divide timing and asynchronous reset.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   stall, stall_tb;
  logic         stallreq;
  logic [158:0] id_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [38:0]  ex_to_id_bus;
  logic [64:0]  ex_hilo_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  int errs = 0;
  int checks = 0;

  ex_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .stallreq       (stallreq),
    .id_to_ex_bus   (id_bus),
    .ex_to_mem_bus  (ex_to_mem_bus),
    .ex_to_id_bus   (ex_to_id_bus),
    .ex_hilo_bus    (ex_hilo_bus),
    .data_sram_en   (data_sram_en),
    .data_sram_wen  (data_sram_wen),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata)
  );

  always #5 clk = ~clk;

  // Stand-in for the stall controller: a divider hold freezes IF..EX
  assign stall = stallreq ? 6'b001111 : stall_tb;

  localparam logic [11:0] ADD = 12'h800, SUB = 12'h400, SLT = 12'h200;
  localparam logic [11:0] SLTU = 12'h100, OR = 12'h020, SRA = 12'h002;
  localparam logic [11:0] LUI = 12'h001;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [158:0] mk(
    input logic [31:0] pc, input logic [31:0] inst,
    input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
    input logic en, input logic [3:0] wen, input logic we,
    input logic [4:0] wa, input logic sr,
    input logic [31:0] d1, input logic [31:0] d2);
    return {pc, inst, op, s1, s2, en, wen, we, wa, sr, d1, d2};
  endfunction

  task automatic alu(input string tag, input logic [158:0] v,
                     input logic [31:0] exp);
    id_bus = v;
    step();
    chk(tag, data_sram_addr, exp);
  endtask

  task automatic do_div(input string tag, input logic [158:0] v,
                        input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi, input bit hold);
    int n;
    id_bus   = v;
    stall_tb = '0;
    step();
    id_bus = '0;
    n = 0;
    while (stallreq === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk({tag, "_stall_cycles"}, n, 33);
    chk({tag, "_we"}, ex_hilo_bus[64], 1'b1);
    chk({tag, "_lo"}, ex_hilo_bus[31:0], exp_lo);
    chk({tag, "_hi"}, ex_hilo_bus[63:32], exp_hi);
    if (hold) begin
      stall_tb = 6'b001111;
      repeat (5) begin
        step();
        chk({tag, "_hold_stallreq"}, stallreq, 1'b0);
        chk({tag, "_hold_we"}, ex_hilo_bus[64], 1'b1);
      end
      stall_tb = '0;
    end
    step();
    chk({tag, "_we_pulse_end"}, ex_hilo_bus[64], 1'b0);
    chk({tag, "_stallreq_end"}, stallreq, 1'b0);
  endtask

  initial begin
    logic [158:0] va;
    id_bus   = '0;
    stall_tb = '0;
    #1;
    chk("rst_mem_bus", ex_to_mem_bus, '0);
    chk("rst_stallreq", stallreq, 1'b0);
    chk("rst_hilo", ex_hilo_bus, '0);
    chk("rst_sram_en", data_sram_en, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    alu("addiu", mk(0, 32'h0000_0001, ADD, 3'b001, 4'b0010, 0, 0, 1, 2, 0,
                    32'h7FFF_FFFF, 0), 32'h8000_0000);
    alu("subu", mk(0, 0, SUB, 3'b001, 4'b0001, 0, 0, 1, 2, 0, 3, 5),
        32'hFFFF_FFFE);
    alu("lui", mk(0, 32'h0000_1234, LUI, 3'b000, 4'b1000, 0, 0, 1, 2, 0,
                  0, 0), 32'h1234_0000);
    alu("ori", mk(0, 32'h0000_000F, OR, 3'b001, 4'b1000, 0, 0, 1, 2, 0,
                  32'hF0, 0), 32'h0000_00FF);
    alu("sra", mk(0, 32'h0000_0100, SRA, 3'b100, 4'b0001, 0, 0, 1, 2, 0,
                  0, 32'h8000_0000), 32'hF800_0000);
    alu("slt", mk(0, 0, SLT, 3'b001, 4'b0001, 0, 0, 1, 2, 0,
                  32'hFFFF_FFFF, 1), 32'd1);
    alu("sltu", mk(0, 0, SLTU, 3'b001, 4'b0001, 0, 0, 1, 2, 0,
                   32'hFFFF_FFFF, 1), 32'd0);
    alu("jal_link", mk(32'hBFC0_0000, 0, ADD, 3'b010, 4'b0100, 0, 0, 1, 31,
                       0, 0, 0), 32'hBFC0_0008);

    va = mk(32'h100, 0, ADD, 3'b001, 4'b0001, 0, 0, 1, 5, 0, 10, 20);
    alu("addu_fwd", va, 32'd30);
    chk("fwd_bus", ex_to_id_bus, {1'b0, 1'b1, 5'd5, 32'd30});
    stall_tb = 6'b000100;
    step();
    chk("bubble_id_bus", ex_to_id_bus, '0);
    chk("bubble_mem_bus", ex_to_mem_bus, '0);
    stall_tb = '0;
    id_bus = va;
    step();
    stall_tb = 6'b001100;
    id_bus = mk(32'h200, 0, SUB, 3'b001, 4'b0001, 1, 4'hF, 1, 7, 1, 1, 2);
    step();
    chk("hold_mem_bus", ex_to_mem_bus,
        {32'h100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'd30});
    stall_tb = '0;

    id_bus = mk(32'h300, 32'h0000_FFFC, ADD, 3'b001, 4'b0010, 1, 4'hF, 0,
                0, 0, 32'h1000, 32'hAB);
    step();
    chk("st_addr", data_sram_addr, 32'h0000_0FFC);
    chk("st_wdata", data_sram_wdata, 32'hAB);
    chk("st_en", data_sram_en, 1'b1);
    chk("st_wen", data_sram_wen, 4'hF);

    do_div("div_m7_2", mk(0, 32'h1A, 0, 0, 0, 0, 0, 0, 0, 0,
                          32'hFFFF_FFF9, 2), 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    do_div("divu_7_0", mk(0, 32'h1B, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0),
           32'hFFFF_FFFF, 32'd7, 0);
    do_div("div_7_m2", mk(0, 32'h1A, 0, 0, 0, 0, 0, 0, 0, 0,
                          7, 32'hFFFF_FFFE), 32'hFFFF_FFFD, 32'd1, 1);

    id_bus = mk(0, 32'h1A, 0, 0, 0, 1, 0, 0, 0, 0, 100, 7);
    step();
    id_bus = '0;
    repeat (10) step();
    chk("pre_rst_stallreq", stallreq, 1'b1);
    chk("pre_rst_sram_en", data_sram_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_stallreq", stallreq, 1'b0);
    chk("mid_rst_hilo", ex_hilo_bus, '0);
    chk("mid_rst_sram_en", data_sram_en, 1'b0);
    #3 rst = 1'b0;
    step();
    chk("post_rst_stallreq", stallreq, 1'b0);
    chk("post_rst_hilo", ex_hilo_bus, '0);
    do_div("divu_100_7", mk(0, 32'h1B, 0, 0, 0, 0, 0, 0, 0, 0, 100, 7),
           32'd14, 32'd2, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
